// File: rtl/push_ctrl_pkg.sv
// Shared types and default timing constants for the push-switch step controller.
package push_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_t;

    localparam int DEB_CYCLES_DEF = 500000;
    localparam int RPT_DELAY_DEF  = 25000000;
    localparam int RPT_PERIOD_DEF = 5000000;
    localparam int MAX_COUNT_DEF  = 255;
    localparam int TMR_W          = 25;
    localparam int CNT_W          = 10;

    // Debounced pattern that keeps a hold in the given direction alive.
    function automatic logic [1:0] dir_pattern(input dir_t d);
        return (d == DIR_UP) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/push_step_ctrl_if.sv
// Switch inputs and step/count outputs of the step controller.
interface push_step_if;
    import push_ctrl_pkg::*;

    logic [1:0]       PUSH;
    logic [CNT_W-1:0] COUNT;
    logic             STEP_UP;
    logic             STEP_DN;
    logic             LOCKED;

    modport master (output PUSH, input COUNT, STEP_UP, STEP_DN, LOCKED);
    modport slave  (input PUSH, output COUNT, STEP_UP, STEP_DN, LOCKED);
endinterface

// File: rtl/push_debounce.sv
// 2-flop synchroniser followed by a stable-count filter for one switch.
module push_debounce
    import push_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          db_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], in};
            // Any return to agreement restarts the stability window.
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                db_q  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign out = db_q;
endmodule

// File: rtl/push_step_ctrl.sv
// Step FSM with auto-repeat timer and wrapping count, fed by two debounced switches.
module push_step_ctrl
    import push_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int RPT_DELAY  = RPT_DELAY_DEF,
    parameter int RPT_PERIOD = RPT_PERIOD_DEF,
    parameter int MAX_COUNT  = MAX_COUNT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    push_step_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic [1:0] db;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_deb
            push_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .CLK (CLK),
                .RST (RST),
                .in  (bus.PUSH[i]),
                .out (db[i])
            );
        end
    endgenerate

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             up_q, up_d, dn_q, dn_d, locked_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tmr_d   = tmr_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (db == 2'b11) begin
                    state_d = ST_LOCK;
                end else if (db != 2'b00) begin
                    dir_d   = (db == 2'b10) ? DIR_UP : DIR_DN;
                    up_d    = (db == 2'b10);
                    dn_d    = (db == 2'b01);
                    tmr_d   = TMR_W'(RPT_DELAY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT, ST_REPEAT: begin
                // Release or a switch to the other button always drops back to IDLE first.
                if (db == 2'b11) begin
                    state_d = ST_LOCK;
                end else if (db != dir_pattern(dir_q)) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    up_d    = (dir_q == DIR_UP);
                    dn_d    = (dir_q == DIR_DN);
                    tmr_d   = TMR_W'(RPT_PERIOD - 1);
                    state_d = ST_REPEAT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                if (db == 2'b00) state_d = ST_IDLE;
            end
        endcase

        count_d = count_q;
        if (up_d)      count_d = (count_q == MAX_C) ? '0 : count_q + CNT_W'(1);
        else if (dn_d) count_d = (count_q == '0) ? MAX_C : count_q - CNT_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_UP;
            tmr_q    <= '0;
            count_q  <= '0;
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            tmr_q    <= tmr_d;
            count_q  <= count_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            locked_q <= (state_d == ST_LOCK);
        end
    end

    assign bus.COUNT   = count_q;
    assign bus.STEP_UP = up_q;
    assign bus.STEP_DN = dn_q;
    assign bus.LOCKED  = locked_q;
endmodule

// File: tb/tb_push_step_ctrl.sv
// Directed bench for push_step_ctrl with small debounce/repeat parameters.
module tb_push_step_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   up_q[$], upc_q[$], dn_q[$], dnc_q[$];
    int   start;

    push_step_if bus();

    push_step_ctrl #(
        .DEB_CYCLES (4),
        .RPT_DELAY  (20),
        .RPT_PERIOD (8),
        .MAX_COUNT  (255)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (bus.STEP_UP) begin up_q.push_back(cyc); upc_q.push_back(int'(bus.COUNT)); end
        if (bus.STEP_DN) begin dn_q.push_back(cyc); dnc_q.push_back(int'(bus.COUNT)); end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        up_q.delete(); upc_q.delete(); dn_q.delete(); dnc_q.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.PUSH = 2'b00;
        wait_cyc(3);
        RST = 1'b0;
        wait_cyc(2);
        clr();
    endtask

    function automatic int at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        bus.PUSH = 2'b00;
        wait_cyc(3);
        chk("reset_count", int'(bus.COUNT), 0);
        chk("reset_up", int'(bus.STEP_UP), 0);
        chk("reset_dn", int'(bus.STEP_DN), 0);
        chk("reset_locked", int'(bus.LOCKED), 0);
        RST = 1'b0;
        wait_cyc(2);
        clr();

        // single press
        start = cyc + 1;
        bus.PUSH = 2'b10;
        wait_cyc(10);
        bus.PUSH = 2'b00;
        wait_cyc(15);
        chk("single_nup", up_q.size(), 1);
        chk("single_lat", at(up_q, 0) - start, 6);
        chk("single_cnt_at_step", at(upc_q, 0), 1);
        chk("single_ndn", dn_q.size(), 0);
        chk("single_count", int'(bus.COUNT), 1);

        // bounce rejection
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.PUSH = 2'b10; wait_cyc(2);
            bus.PUSH = 2'b00; wait_cyc(2);
        end
        wait_cyc(10);
        chk("bounce_nup", up_q.size(), 0);
        chk("bounce_count", int'(bus.COUNT), 0);

        // hold with repeat
        do_reset();
        start = cyc + 1;
        bus.PUSH = 2'b10;
        wait_cyc(60);
        bus.PUSH = 2'b00;
        wait_cyc(20);
        chk("hold_nup", up_q.size(), 6);
        chk("hold_first", at(up_q, 0) - start, 6);
        chk("hold_rpt1", at(up_q, 1) - at(up_q, 0), 20);
        chk("hold_rpt2", at(up_q, 2) - at(up_q, 0), 28);
        chk("hold_rpt3", at(up_q, 3) - at(up_q, 0), 36);
        chk("hold_rpt4", at(up_q, 4) - at(up_q, 0), 44);
        chk("hold_rpt5", at(up_q, 5) - at(up_q, 0), 52);
        chk("hold_count", int'(bus.COUNT), 6);

        // wrap-around both ways
        do_reset();
        bus.PUSH = 2'b01;
        wait_cyc(10);
        bus.PUSH = 2'b00;
        wait_cyc(15);
        chk("wrap_ndn", dn_q.size(), 1);
        chk("wrap_dn_count", int'(bus.COUNT), 255);
        bus.PUSH = 2'b10;
        wait_cyc(10);
        bus.PUSH = 2'b00;
        wait_cyc(15);
        chk("wrap_nup", up_q.size(), 1);
        chk("wrap_up_count", int'(bus.COUNT), 0);

        // simultaneous press and lock release
        do_reset();
        bus.PUSH = 2'b11;
        wait_cyc(6);
        chk("lock_before", int'(bus.LOCKED), 0);
        wait_cyc(1);
        chk("lock_rise", int'(bus.LOCKED), 1);
        wait_cyc(5);
        bus.PUSH = 2'b10;
        wait_cyc(12);
        chk("lock_partial", int'(bus.LOCKED), 1);
        chk("lock_nstep", up_q.size() + dn_q.size(), 0);
        bus.PUSH = 2'b00;
        wait_cyc(12);
        chk("lock_fall", int'(bus.LOCKED), 0);
        bus.PUSH = 2'b10;
        wait_cyc(10);
        bus.PUSH = 2'b00;
        wait_cyc(15);
        chk("unlock_nup", up_q.size(), 1);
        chk("unlock_count", int'(bus.COUNT), 1);

        // reset in the middle of a repeat hold
        do_reset();
        bus.PUSH = 2'b10;
        wait_cyc(52);
        chk("mid_count", int'(bus.COUNT), 5);
        RST = 1'b1;
        #1;
        chk("rst_async_count", int'(bus.COUNT), 0);
        chk("rst_async_up", int'(bus.STEP_UP), 0);
        chk("rst_async_locked", int'(bus.LOCKED), 0);
        wait_cyc(3);
        clr();
        RST = 1'b0;
        start = cyc + 1;
        wait_cyc(30);
        chk("rerun_first", at(up_q, 0) - start, 6);
        chk("rerun_cnt", at(upc_q, 0), 1);
        chk("rerun_rpt", at(up_q, 1) - at(up_q, 0), 20);
        bus.PUSH = 2'b00;
        wait_cyc(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
